// File: rtl/result_writer.sv
// Result writer: streams one frame of DEPTH result words into memory starting at BASE_ADDR,
// either stopping when the frame is complete or wrapping continuously.
module result_writer #(
    parameter int DATA_W    = 24,
    parameter int ADDR_W    = 4,
    parameter int DEPTH     = 9,
    parameter int BASE_ADDR = 0,
    parameter int WRAP      = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              frame_done,
    output logic [7:0]        frame_cnt,
    output logic              full,
    output logic              overflow
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic              WRAP_EN  = (WRAP != 0);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_ready;
    logic              w_accept;
    logic              w_last;
    logic [ADDR_W:0]   r_index;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_frame_done;
    logic [7:0]        r_frame_cnt;
    logic              r_overflow;

    assign w_ready  = (r_state == ST_RUN) && !clear && !reset;
    assign w_accept = in_valid && w_ready;
    assign w_last   = (r_index == LAST_IDX);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: clear always returns to RUN, last word of a stop-mode frame goes FULL
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_accept && w_last && !WRAP_EN) begin
                    w_state_nxt = ST_FULL;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_FULL: w_state_nxt = ST_FULL;
            default: w_state_nxt = ST_RUN;
        endcase
        if (clear) begin
            w_state_nxt = ST_RUN;
        end else begin
            w_state_nxt = w_state_nxt;
        end
    end

    // Write launch, frame indexing and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_index      <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= 8'd0;
            r_overflow   <= 1'b0;
        end else if (clear) begin
            r_index      <= '0;
            r_mem_we     <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_mem_we     <= w_accept;
            r_frame_done <= w_accept && w_last;
            if (w_accept) begin
                r_mem_addr  <= BASE_A + r_index[ADDR_W-1:0];
                r_mem_wdata <= in_data;
                if (w_last) begin
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                    r_index     <= WRAP_EN ? '0 : DEPTH_C;
                end else begin
                    r_index <= r_index + (ADDR_W+1)'(1);
                end
            end
            if ((r_state == ST_FULL) && in_valid) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Reset forces every output low immediately, which also kills a write launched just before it
    assign in_ready   = w_ready;
    assign mem_we     = r_mem_we && !reset;
    assign mem_addr   = reset ? '0 : r_mem_addr;
    assign mem_wdata  = reset ? '0 : r_mem_wdata;
    assign count      = reset ? '0 : r_index;
    assign frame_done = r_frame_done && !reset;
    assign frame_cnt  = reset ? 8'd0 : r_frame_cnt;
    assign full       = (r_state == ST_FULL) && !reset;
    assign overflow   = r_overflow && !reset;

endmodule
